lif_cmd_sequencer: RTL and testbench
====================================

// Module: lif_cmd_sequencer
// PURPOSE
//  Byte-command front end for the LIF neuron datapath. Parses a header+payload byte stream on a
//  valid/ready port, shifts weight/input bytes into the neuron, and runs it for N membrane steps.
//  Counts output spikes per run. Sits between the pin/host byte source and the neuron core.
// PARAMETERS
//  N_STAGES        5    neuron adder-tree depth; INPUTS = 2**N_STAGES synapses
//  LOAD_BYTES      max(1, INPUTS/8) (derived, localparam)  payload bytes per LOAD command
//  SPIKE_CNT_BITS  8    spike counter width
// PORTS
//  clk               in   1  clock, all state on rising edge
//  reset             in   1  asynchronous, active-high; clears all state
//  cmd_valid         in   1  cmd_data holds a byte
//  cmd_data          in   8  header or payload byte
//  cmd_ready         out  1  byte accepted on a cycle where cmd_valid & cmd_ready
//  nrn_data          out  8  byte shifted into neuron weights/inputs
//  nrn_load          out  1  1-cycle strobe: shift nrn_data in this cycle
//  nrn_load_weights  out  1  with nrn_load: 1 = weights register, 0 = inputs register
//  nrn_step          out  1  advance membrane (last_membrane <= new_membrane) this cycle
//  nrn_spike         in   1  neuron is_spike, sampled only when nrn_step=1
//  busy              out  1  state != IDLE
//  done              out  1  1-cycle pulse after the final step of a RUN
//  spike_count       out  SPIKE_CNT_BITS  spikes seen in the current/last RUN
// BEHAVIOUR
//  Header byte: [7:6] opcode, [5:0] arg. 00 LOAD_W, 01 LOAD_I, 10 RUN (arg steps, 0 => 64), 11 see CONFIG.
//  FSM: IDLE -> LOAD (on 00/01 header) -> IDLE after LOAD_BYTES payload bytes accepted.
//       IDLE -> RUN (on 10 header) -> IDLE after arg steps; done pulses the cycle after the last step.
//  cmd_ready = 1 in IDLE and LOAD; 0 in RUN. Bytes are not dropped: valid held by source until ready.
//  Payload accepted cycle T -> nrn_load=1, nrn_data=byte, nrn_load_weights=opcode[0]==0 at T+1 (registered).
//  Payload byte order: first byte lands deepest (neuron shifts left by 8); no reordering here.
//  RUN: nrn_step=1 for exactly arg (or 64) consecutive cycles starting cycle after header accept.
//  nrn_load and nrn_step never both 1. nrn_step=0 whenever not in RUN (neuron holds membrane).
//  spike_count cleared to 0 on RUN header accept; +1 per step cycle with nrn_spike=1;
//   saturates at 2**SPIKE_CNT_BITS-1; holds value in IDLE/LOAD until next RUN.
//  Step counter 7 bits, loaded with arg (0 -> 64), decremented per step; exit at 1->0.
//  Reset values: all outputs 0 except cmd_ready=1 after reset deasserts; state IDLE; counters 0.
//  Reset mid-LOAD: partial payload abandoned; neuron keeps partially shifted bytes; host reloads.
//  Reset mid-RUN: stepping stops immediately, no done pulse, spike_count=0.
//  cmd_valid during RUN: ignored, not consumed. Header with unknown/NOP opcode consumed in 1 cycle.
// CONFIGURATION
//  LIF_SEQ_FREERUN_EN defined: opcode 11 = FREERUN: nrn_step=1 every cycle, cmd_ready=1,
//   spike_count cleared on entry and counts as in RUN; next accepted byte ends FREERUN (no step
//   that cycle's successor) and is decoded as a new header in the same accept. No done pulse.
//  Not defined: opcode 11 = NOP, byte consumed, no outputs, state stays IDLE.
// TESTING
//  1. Reset, N_STAGES=5: send 0x00,A1,A2,A3,A4 -> 4 nrn_load pulses, weights=1, data A1..A4, busy drops after A4.
//  2. Send 0x40 then 4 bytes with cmd_valid gapped -> nrn_load only on accepted bytes, weights=0, count exact.
//  3. RUN 0x85 with nrn_spike tied 1 -> nrn_step high 5 cycles, spike_count=5, done 1 cycle, cmd_ready low meanwhile.
//  4. RUN 0x80 (64 steps), SPIKE_CNT_BITS=5, spike=1 -> 64 steps, spike_count saturates at 31.
//  5. Assert reset at step 3 of RUN 0x8A -> nrn_step=0 at once, no done, spike_count=0, cmd_ready=1 after release.
//  6. Header 0xC0: without LIF_SEQ_FREERUN_EN no steps; with it steps every cycle until 0x85 accepted, then 5-step RUN.

Source files
------------

// File: rtl/lif_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------------+
// | lif_cmd_sequencer: byte-command parser driving LIF neuron loads/steps, counts     |
// | spikes per RUN. Optional macro LIF_SEQ_FREERUN_EN enables opcode 11 = FREERUN.   |
// | Rev 1.0                                                                          |
// +----------------------------------------------------------------------------------+
module lif_cmd_sequencer #(
  parameter int N_STAGES       = 5,
  parameter int SPIKE_CNT_BITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_cmd_valid,
  input  logic [7:0]                i_cmd_data,
  output logic                      o_cmd_ready,
  output logic [7:0]                o_nrn_data,
  output logic                      o_nrn_load,
  output logic                      o_nrn_load_weights,
  output logic                      o_nrn_step,
  input  logic                      i_nrn_spike,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [SPIKE_CNT_BITS-1:0] o_spike_count
);

  localparam int c_inputs     = 2**N_STAGES;
  localparam int c_load_bytes = (c_inputs / 8 > 1) ? (c_inputs / 8) : 1;
  localparam int c_bcnt_w     = $clog2(c_load_bytes + 1);
  localparam logic [c_bcnt_w-1:0] c_last_byte = c_bcnt_w'(c_load_bytes - 1);
  localparam logic [SPIKE_CNT_BITS-1:0] c_spk_max = {SPIKE_CNT_BITS{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FREE = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [c_bcnt_w-1:0]       r_bcnt;
  logic [6:0]                r_step_cnt;
  logic                      r_load_w;
  logic [7:0]                r_nrn_data;
  logic                      r_nrn_load;
  logic                      r_done;
  logic [SPIKE_CNT_BITS-1:0] r_spike_cnt;

  logic       w_hdr_accept;
  logic       w_step;
  logic [1:0] w_opcode;
  logic [6:0] w_run_len;

  assign w_opcode  = i_cmd_data[7:6];
  assign w_run_len = (i_cmd_data[5:0] == 6'd0) ? 7'd64 : {1'b0, i_cmd_data[5:0]};

  always_comb begin
    w_state_nxt  = r_state;
    w_hdr_accept = 1'b0;
    w_step       = (r_state == S_RUN) || (r_state == S_FREE);
    // Ready is held low while reset is asserted so the host cannot hand over a byte then
    o_cmd_ready  = !reset && (r_state != S_RUN);
    o_busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE, S_FREE: begin
        if (i_cmd_valid) begin
          w_hdr_accept = 1'b1;
          case (w_opcode)
            2'b00, 2'b01: w_state_nxt = S_LOAD;
            2'b10:        w_state_nxt = S_RUN;
            default: begin
`ifdef LIF_SEQ_FREERUN_EN
              w_state_nxt = S_FREE;
`else
              w_state_nxt = S_IDLE;
`endif
            end
          endcase
        end
      end
      S_LOAD: begin
        if (i_cmd_valid && (r_bcnt == c_last_byte)) w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (r_step_cnt == 7'd1) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bcnt      <= '0;
      r_step_cnt  <= '0;
      r_load_w    <= 1'b0;
      r_nrn_data  <= '0;
      r_nrn_load  <= 1'b0;
      r_done      <= 1'b0;
      r_spike_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_nrn_load <= 1'b0;
      r_done     <= (r_state == S_RUN) && (r_step_cnt == 7'd1);

      if (w_hdr_accept && !w_opcode[1]) begin
        r_load_w <= ~w_opcode[0];
        r_bcnt   <= '0;
      end
      if (w_hdr_accept && (w_opcode == 2'b10)) r_step_cnt <= w_run_len;

      if ((r_state == S_LOAD) && i_cmd_valid) begin
        r_nrn_load <= 1'b1;
        r_nrn_data <= i_cmd_data;
        r_bcnt     <= r_bcnt + 1'b1;
      end

      if (r_state == S_RUN) r_step_cnt <= r_step_cnt - 7'd1;

      // A header accepted out of FREERUN clears the count, so the clear comes last
      if (w_step && i_nrn_spike && (r_spike_cnt != c_spk_max)) r_spike_cnt <= r_spike_cnt + 1'b1;
      if (w_hdr_accept && (w_opcode == 2'b10)) r_spike_cnt <= '0;
`ifdef LIF_SEQ_FREERUN_EN
      if (w_hdr_accept && (w_opcode == 2'b11)) r_spike_cnt <= '0;
`endif
    end
  end

  assign o_nrn_data         = r_nrn_data;
  assign o_nrn_load         = r_nrn_load;
  assign o_nrn_load_weights = r_nrn_load & r_load_w;
  assign o_nrn_step         = w_step;
  assign o_done             = r_done;
  assign o_spike_count      = r_spike_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lif_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------------+
// | tb_lif_cmd_sequencer: directed + randomized check of LOAD/RUN/NOP command flow.   |
// | Rev 1.0                                                                          |
// +----------------------------------------------------------------------------------+
module tb_lif_cmd_sequencer;

  localparam int N_STAGES       = 5;
  localparam int SPIKE_CNT_BITS = 5;
  localparam int LOAD_BYTES     = 4;
  localparam int SAT            = 31;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      i_cmd_valid = 1'b0;
  logic [7:0]                i_cmd_data = 8'h00;
  logic                      o_cmd_ready;
  logic [7:0]                o_nrn_data;
  logic                      o_nrn_load;
  logic                      o_nrn_load_weights;
  logic                      o_nrn_step;
  logic                      i_nrn_spike = 1'b0;
  logic                      o_busy;
  logic                      o_done;
  logic [SPIKE_CNT_BITS-1:0] o_spike_count;

  always #5 clk = ~clk;

  lif_cmd_sequencer #(
    .N_STAGES       (N_STAGES),
    .SPIKE_CNT_BITS (SPIKE_CNT_BITS)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .i_cmd_valid        (i_cmd_valid),
    .i_cmd_data         (i_cmd_data),
    .o_cmd_ready        (o_cmd_ready),
    .o_nrn_data         (o_nrn_data),
    .o_nrn_load         (o_nrn_load),
    .o_nrn_load_weights (o_nrn_load_weights),
    .o_nrn_step         (o_nrn_step),
    .i_nrn_spike        (i_nrn_spike),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_spike_count      (o_spike_count)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level observations gathered on the falling edge
  int         cyc = 0;
  int         steps, exp_spk, dones, overlap, ready_in_run;
  int         first_step, last_step, done_cyc;
  int         spike_mode = 0;
  logic       spike_now;
  logic [8:0] load_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    case (spike_mode)
      0:       spike_now = 1'b0;
      1:       spike_now = 1'b1;
      default: spike_now = 1'($urandom_range(0, 1));
    endcase
    i_nrn_spike = spike_now;
    if (!reset) begin
      if (o_nrn_load) load_q.push_back({o_nrn_load_weights, o_nrn_data});
      if (o_nrn_step) begin
        if (steps == 0) first_step = cyc;
        last_step = cyc;
        steps++;
        if (spike_now) exp_spk++;
        if (o_cmd_ready) ready_in_run++;
      end
      if (o_nrn_load && o_nrn_step) overlap++;
      if (o_done) begin
        dones++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    steps = 0; exp_spk = 0; dones = 0; overlap = 0; ready_in_run = 0;
    first_step = -1; last_step = -1; done_cyc = -1;
    load_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard = 0;
    repeat (gap) step_cyc();
    i_cmd_valid = 1'b1;
    i_cmd_data  = b;
    while (!o_cmd_ready && guard < 300) begin
      step_cyc();
      guard++;
    end
    if (guard >= 300) check("accept_timeout", 32'd0, 32'd1);
    step_cyc();
    i_cmd_valid = 1'b0;
    i_cmd_data  = 8'($urandom);
  endtask

  task automatic wait_done();
    int g = 0;
    while (dones == 0 && g < 150) begin
      step_cyc();
      g++;
    end
    check("done_seen", 32'(dones), 32'd1);
  endtask

  task automatic do_load(input logic op, input logic [7:0] p [LOAD_BYTES], input int gap);
    clr();
    send_byte({1'b0, op, 6'($urandom)}, $urandom_range(0, gap));
    check("load_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < LOAD_BYTES; i++) send_byte(p[i], $urandom_range(0, gap));
    step_cyc();
    check("load_count", 32'(load_q.size()), 32'(LOAD_BYTES));
    for (int i = 0; i < LOAD_BYTES; i++)
      if (i < load_q.size()) check("load_entry", 32'(load_q[i]), 32'({~op, p[i]}));
    check("load_idle", 32'(o_busy), 32'd0);
    check("load_nostep", 32'(steps), 32'd0);
  endtask

  task automatic do_run(input logic [5:0] arg, input int mode, input int gap);
    int n, acc, want;
    clr();
    spike_mode = mode;
    send_byte({2'b10, arg}, gap);
    acc = cyc;
    n   = (arg == 6'd0) ? 64 : int'(arg);
    wait_done();
    want = (exp_spk > SAT) ? SAT : exp_spk;
    check("run_steps", 32'(steps), 32'(n));
    check("run_first", 32'(first_step), 32'(acc));
    check("run_contig", 32'(last_step - first_step + 1), 32'(n));
    check("run_done_at", 32'(done_cyc), 32'(last_step + 1));
    check("run_spikes", 32'(o_spike_count), 32'(want));
    check("run_idle", 32'(o_busy), 32'd0);
    check("run_ready_low", 32'(ready_in_run), 32'd0);
    check("run_overlap", 32'(overlap), 32'd0);
    step_cyc();
    check("done_pulse", 32'(o_done), 32'd0);
    check("done_once", 32'(dones), 32'd1);
    check("spk_hold", 32'(o_spike_count), 32'(want));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p [LOAD_BYTES];
    int         g;

    clr();
    step_cyc();
    check("rst_ready", 32'(o_cmd_ready), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_load", 32'(o_nrn_load), 32'd0);
    check("rst_step", 32'(o_nrn_step), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_spk", 32'(o_spike_count), 32'd0);
    check("rst_data", 32'(o_nrn_data), 32'd0);
    step_cyc();
    reset = 1'b0;
    step_cyc();
    check("post_rst_ready", 32'(o_cmd_ready), 32'd1);

    // LOAD_W with fixed payload, back-to-back
    p = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    do_load(1'b0, p, 0);
    // LOAD_I with gapped valid
    for (int i = 0; i < LOAD_BYTES; i++) p[i] = 8'($urandom);
    do_load(1'b1, p, 3);

    do_run(6'd5, 1, 0);
    do_run(6'd0, 1, 0);  // 64 steps, count saturates

    // Byte presented during RUN must wait, then be taken as a header
    clr();
    spike_mode = 1;
    send_byte(8'h85, 0);
    i_cmd_valid = 1'b1;
    i_cmd_data  = 8'h40;
    wait_done();
    check("hold_steps", 32'(steps), 32'd5);
    check("hold_spk", 32'(o_spike_count), 32'd5);
    check("hold_ready_low", 32'(ready_in_run), 32'd0);
    check("hold_noload", 32'(load_q.size()), 32'd0);
    step_cyc();
    i_cmd_valid = 1'b0;
    check("hold_taken", 32'(o_busy), 32'd1);
    for (int i = 0; i < LOAD_BYTES; i++) begin
      p[i] = 8'($urandom);
      send_byte(p[i], 0);
    end
    step_cyc();
    check("hold_load_count", 32'(load_q.size()), 32'(LOAD_BYTES));
    for (int i = 0; i < LOAD_BYTES; i++)
      if (i < load_q.size()) check("hold_load_entry", 32'(load_q[i]), 32'({1'b0, p[i]}));

    // Reset in the middle of a RUN
    clr();
    spike_mode = 1;
    send_byte(8'h8A, 0);
    g = 0;
    while (steps < 3 && g < 50) begin
      step_cyc();
      g++;
    end
    check("mid_reached", 32'(steps), 32'd3);
    reset = 1'b1;
    #1;
    check("mid_step_off", 32'(o_nrn_step), 32'd0);
    check("mid_spk_clr", 32'(o_spike_count), 32'd0);
    check("mid_busy", 32'(o_busy), 32'd0);
    step_cyc();
    step_cyc();
    reset = 1'b0;
    repeat (12) step_cyc();
    check("mid_ready", 32'(o_cmd_ready), 32'd1);
    check("mid_nodone", 32'(dones), 32'd0);
    check("mid_nosteps", 32'(steps), 32'd3);

    // Opcode 11 is consumed and does nothing
    clr();
    send_byte(8'hC0, 0);
    repeat (4) step_cyc();
    check("nop_busy", 32'(o_busy), 32'd0);
    check("nop_steps", 32'(steps), 32'd0);
    check("nop_loads", 32'(load_q.size()), 32'd0);

    // Randomized command mix
    repeat (30) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          for (int i = 0; i < LOAD_BYTES; i++) p[i] = 8'($urandom);
          do_load(1'($urandom_range(0, 1)), p, 2);
        end
        4, 5, 6, 7: begin
          do_run(($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 20)),
                 $urandom_range(0, 2), $urandom_range(0, 2));
        end
        default: begin
          clr();
          send_byte({2'b11, 6'($urandom)}, $urandom_range(0, 2));
          repeat (3) step_cyc();
          check("rnop_busy", 32'(o_busy), 32'd0);
          check("rnop_steps", 32'(steps), 32'd0);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
